multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
- REQ-001: Parameter MAX_WAIT, default 15: maximum cycles a memory access may wait for MemReady before a timeout trap.
- REQ-002: clk  in  1  single clock; all state changes on its rising edge.
- REQ-003: rst_n  in  1  asynchronous, active-low reset.
- REQ-004: op  in  7  opcode field Instr[6:0] from the instruction register.
- REQ-005: funct3  in  3  Instr[14:12]; funct7b5  in  1  Instr[30].
- REQ-006: Zero  in  1  ALU zero flag.
- REQ-007: MemReady  in  1  memory access completes this cycle.
- REQ-008: MemReq  out  1  memory access active; AdrSrc  out  1  address select (0=PC, 1=ALUOut).
- REQ-009: MemWrite, IRWrite, PCWrite, RegWrite  out  1 each  write strobes.
- REQ-010: ResultSrc  out  2  (00=ALUOut, 01=Data, 10=ALUResult).
- REQ-011: ALUSrcA  out  2  (00=PC, 01=OldPC, 10=RD1); ALUSrcB  out  2  (00=RD2, 01=Imm, 10=const 4).
- REQ-012: ALUControl  out  3  (000 add, 001 sub, 010 and, 011 or, 101 slt).
- REQ-013: ImmSel  out  3  extender select: 000 I, 001 S, 010 B, 011 U, 100 J.
- REQ-014: Illegal, MemTimeout  out  1 each  sticky error flags; State  out  4  current state code.

Function
- REQ-015: States and codes SHALL be FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, LUI 11, TRAP 12.
- REQ-016: FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10; on MemReady: IRWrite=1, PCWrite=1, go DECODE; else stay.
- REQ-017: DECODE: ImmSel=010, ALUSrcA=01, ALUSrcB=01, add (branch target precompute); next by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL, 0110111 -> LUI, any other -> TRAP with Illegal set.
- REQ-018: MEMADR: ALUSrcA=10, ALUSrcB=01, add; ImmSel=000 for load (-> MEMREAD), 001 for store (-> MEMWRITE).
- REQ-019: MEMREAD: MemReq=1, AdrSrc=1; on MemReady -> MEMWB. MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- REQ-020: MEMWRITE: MemReq=1, AdrSrc=1, MemWrite=1 held until MemReady, then -> FETCH.
- REQ-021: EXECR: ALUSrcA=10, ALUSrcB=00; ALUControl from funct3: 000 -> sub if funct7b5 else add, 010 slt, 110 or, 111 and, other funct3 -> TRAP with Illegal; else -> ALUWB.
- REQ-022: EXECI: as EXECR but ALUSrcB=01, ImmSel=000, funct3=000 always add.
- REQ-023: ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- REQ-024: BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00; PCWrite = Zero when funct3=000, !Zero when 001, other funct3 -> TRAP with Illegal; -> FETCH.
- REQ-025: JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, ImmSel=100 -> ALUWB.
- REQ-026: LUI: ImmSel=011, ALUSrcB=01, ResultSrc=10, RegWrite=1 -> FETCH.
- REQ-027: A 4-bit-min wait counter SHALL clear on entry to each MemReq state and increment each cycle MemReady=0; on reaching MAX_WAIT with MemReady=0: set MemTimeout, drop MemReq/MemWrite, -> TRAP.
- REQ-028: MemReady=1 on the same cycle the counter reaches MAX_WAIT SHALL complete normally (no timeout).
- REQ-029: TRAP: all strobes 0, MemReq=0; state held until reset.
- REQ-030: Strobes and selects not listed for a state SHALL be 0; ImmSel unlisted = 000.
- REQ-031: Outputs SHALL be Moore decodes of State except PCWrite in BRANCH and IRWrite/PCWrite in FETCH (qualified by Zero/MemReady).

Reset
- REQ-032: rst_n=0 SHALL immediately force State=FETCH, wait counter=0, Illegal=0, MemTimeout=0, even mid-access; first fetch begins in the first cycle after rst_n rises.

Verification
- REQ-033: Reset, MemReady=1 always, op=0110011 funct3=000 funct7b5=1 -> states 0,1,6,8,0; ALUControl=001 in EXECR, RegWrite=1 in ALUWB only.
- REQ-034: Load op=0000011, MemReady low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB with ResultSrc=01, RegWrite=1.
- REQ-035: BEQ op=1100011 funct3=000, Zero=1 then repeat with Zero=0 -> PCWrite=1 in BRANCH first pass, 0 second; ImmSel=010 in DECODE.
- REQ-036: op=1111111 in DECODE -> State=12, Illegal=1, all strobes 0 for 10+ cycles; rst_n pulse clears to State=0.
- REQ-037: MAX_WAIT=15, MemReady=0 in FETCH -> MemTimeout=1, State=12 after 15 cycles; MemReady=1 on the 15th cycle -> DECODE, no timeout.
- REQ-038: rst_n asserted mid-MEMWRITE -> MemWrite drops to 0 asynchronously, State=0 with no clock edge.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Main control FSM of a multicycle RV32 subset core (loads, stores,
//   R-type, I-type ALU, BEQ/BNE, JAL, LUI). It drives the datapath mux
//   selects, ALU operation and write strobes for the current state. Memory
//   accesses are guarded by a wait counter that traps when MemReady never
//   arrives.
//
//   Memory handshake: MemReq is the request (valid) and MemReady is the
//   completion (ready). An access finishes in the first cycle where both are
//   1. While waiting, the controller holds MemReq, AdrSrc and MemWrite
//   steady. If MAX_WAIT cycles pass with MemReady still 0, it abandons the
//   access and goes to TRAP.
//
// Parameters
//   MAX_WAIT   most cycles one memory access may spend waiting (>= 1)
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   op, funct3, funct7b5       instruction fields from the IR
//   Zero                       ALU zero flag (branch condition)
//   MemReady                   memory access completes this cycle
//   MemReq, AdrSrc, MemWrite   memory request, address select, write strobe
//   IRWrite, PCWrite, RegWrite architectural write strobes
//   ResultSrc, ALUSrcA/B       datapath mux selects
//   ALUControl, ImmSel         ALU operation, immediate format
//   Illegal, MemTimeout        sticky error flags (cleared only by reset)
//   State                      current state code (debug / checker visibility)
module multicycle_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSel,
  output logic       Illegal,
  output logic       MemTimeout,
  output logic [3:0] State
);

  // The wait counter is at least 4 bits wide, and wide enough to hold MAX_WAIT.
  localparam int CW = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;
  // This is the last count value that still allows one more waiting cycle.
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_LUI      = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  logic [3:0]    state, state_nx;
  logic [CW-1:0] wait_cnt;
  logic          illegal_q, timeout_q;
  logic          set_illegal, set_timeout;
  logic          mem_state, wait_expired;
  logic [2:0]    alu_op;
  logic          f3_ok;

  assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) ||
                     (state == S_MEMWRITE);
  // A completion (MemReady=1) in the last allowed cycle still wins over the
  // timeout.
  assign wait_expired = mem_state && !MemReady && (wait_cnt >= WAIT_LAST);

  // Decode the ALU operation for EXECR/EXECI. funct7b5 selects sub only for
  // R-type; for I-type, bit 30 is part of the immediate.
  always_comb begin
    alu_op = ALU_ADD;
    f3_ok  = 1'b1;
    case (funct3)
      3'b000:  alu_op = (state == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_op = ALU_SLT;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: f3_ok  = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nx    = state;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state)
      S_FETCH: begin
        if (MemReady) begin
          state_nx = S_DECODE;
        end else if (wait_expired) begin
          state_nx    = S_TRAP;
          set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_nx = S_MEMADR;
          OP_R:              state_nx = S_EXECR;
          OP_I:              state_nx = S_EXECI;
          OP_BR:             state_nx = S_BRANCH;
          OP_JAL:            state_nx = S_JAL;
          OP_LUI:            state_nx = S_LUI;
          default: begin
            state_nx    = S_TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_nx = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (MemReady) begin
          state_nx = S_MEMWB;
        end else if (wait_expired) begin
          state_nx    = S_TRAP;
          set_timeout = 1'b1;
        end
      end
      S_MEMWB:    state_nx = S_FETCH;
      S_MEMWRITE: begin
        if (MemReady) begin
          state_nx = S_FETCH;
        end else if (wait_expired) begin
          state_nx    = S_TRAP;
          set_timeout = 1'b1;
        end
      end
      S_EXECR, S_EXECI: begin
        if (f3_ok) begin
          state_nx = S_ALUWB;
        end else begin
          state_nx    = S_TRAP;
          set_illegal = 1'b1;
        end
      end
      S_ALUWB:    state_nx = S_FETCH;
      S_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          state_nx = S_FETCH;
        end else begin
          state_nx    = S_TRAP;
          set_illegal = 1'b1;
        end
      end
      S_JAL:      state_nx = S_ALUWB;
      S_LUI:      state_nx = S_FETCH;
      S_TRAP:     state_nx = S_TRAP;
      default:    state_nx = S_TRAP;  // unused codes 13..15
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nx;
      // The counter restarts on every state change. It only advances while
      // a memory state is stalled. It never wraps, because wait_expired
      // leaves the state first.
      if (state_nx != state) begin
        wait_cnt <= '0;
      end else if (mem_state && !MemReady) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  // Output decode is Moore, except for IRWrite/PCWrite in FETCH and
  // PCWrite in BRANCH.
  always_comb begin
    MemReq     = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    ImmSel     = IMM_I;
    case (state)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      S_DECODE: begin
        ImmSel  = IMM_B;  // branch target is precomputed into ALUOut
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSel  = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_op;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_op;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        case (funct3)
          3'b000:  PCWrite = Zero;
          3'b001:  PCWrite = !Zero;
          default: PCWrite = 1'b0;
        endcase
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        ImmSel  = IMM_J;
      end
      S_LUI: begin
        ImmSel    = IMM_U;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        RegWrite  = 1'b1;
      end
      default: ;  // TRAP and unused codes: everything stays quiet
    endcase
  end

  assign Illegal    = illegal_q;
  assign MemTimeout = timeout_q;
  assign State      = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl (MAX_WAIT = 15). Each driven cycle
//   pushes one hand-computed expected output vector. A monitor pops and
//   compares one vector at each falling edge, and also when the driver
//   raises chk_now for checks taken between clock edges.
//   Vector layout: {State[3:0], MemReq, AdrSrc, MemWrite, IRWrite, PCWrite,
//   RegWrite, ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0], ALUControl[2:0],
//   ImmSel[2:0], Illegal, MemTimeout}
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       MemReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSel;
  logic       Illegal, MemTimeout;
  logic [3:0] State;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .MemReq(MemReq), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSel(ImmSel),
    .Illegal(Illegal), .MemTimeout(MemTimeout), .State(State)
  );

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  event        chk_now;
  logic [23:0] act;

  assign act = {State, MemReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSel, Illegal,
                MemTimeout};

  task automatic check_one();
    logic [23:0] e;
    string       nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, e, $time);
      end
    end
  endtask

  always @(negedge clk) check_one();
  always @(chk_now) check_one();

  // Expected-vector builders (values tabulated by hand from the state list)
  function automatic logic [23:0] mk(input logic [3:0] st, input logic [5:0] stb,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] alu,
                                     input logic [2:0] imm, input logic [1:0] fl);
    return {st, stb, rs, sa, sb, alu, imm, fl};
  endfunction

  // The strobes field is {MemReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite}.
  function automatic logic [23:0] ex_fetch(input logic rdy, input logic [1:0] fl);
    return mk(4'd0, {1'b1, 1'b0, 1'b0, rdy, rdy, 1'b0}, 2'b10, 2'b00, 2'b10,
              3'b000, 3'b000, fl);
  endfunction
  function automatic logic [23:0] ex_decode();
    return mk(4'd1, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010, 2'b00);
  endfunction
  function automatic logic [23:0] ex_aluwb();
    return mk(4'd8, 6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00);
  endfunction
  function automatic logic [23:0] ex_trap(input logic [1:0] fl);
    return mk(4'd12, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, fl);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push(input string nm, input logic [23:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic cyc(input string nm, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic rdy,
                     input logic [23:0] e);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    Zero     = z;
    MemReady = rdy;
    push(nm, e);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    MemReady = 1'b0;
    push(nm, ex_fetch(1'b0, 2'b00));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset("reset_state");

    // R-type sub: states 0,1,6,8
    cyc("r_sub_fetch",  OP_R, 3'b000, 1'b1, 1'b0, 1'b1, ex_fetch(1'b1, 2'b00));
    cyc("r_sub_decode", OP_R, 3'b000, 1'b1, 1'b0, 1'b1, ex_decode());
    cyc("r_sub_execr",  OP_R, 3'b000, 1'b1, 1'b0, 1'b1,
        mk(4'd6, 6'b000000, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 2'b00));
    cyc("r_sub_aluwb",  OP_R, 3'b000, 1'b1, 1'b0, 1'b1, ex_aluwb());

    // R-type slt
    cyc("r_slt_fetch",  OP_R, 3'b010, 1'b0, 1'b0, 1'b1, ex_fetch(1'b1, 2'b00));
    cyc("r_slt_decode", OP_R, 3'b010, 1'b0, 1'b0, 1'b1, ex_decode());
    cyc("r_slt_execr",  OP_R, 3'b010, 1'b0, 1'b0, 1'b1,
        mk(4'd6, 6'b000000, 2'b00, 2'b10, 2'b00, 3'b101, 3'b000, 2'b00));
    cyc("r_slt_aluwb",  OP_R, 3'b010, 1'b0, 1'b0, 1'b1, ex_aluwb());

    // I-type ori, then addi with bit 30 set (must still add)
    cyc("i_or_fetch",  OP_I, 3'b110, 1'b0, 1'b0, 1'b1, ex_fetch(1'b1, 2'b00));
    cyc("i_or_decode", OP_I, 3'b110, 1'b0, 1'b0, 1'b1, ex_decode());
    cyc("i_or_execi",  OP_I, 3'b110, 1'b0, 1'b0, 1'b1,
        mk(4'd7, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b011, 3'b000, 2'b00));
    cyc("i_or_aluwb",  OP_I, 3'b110, 1'b0, 1'b0, 1'b1, ex_aluwb());
    cyc("i_add_fetch",  OP_I, 3'b000, 1'b1, 1'b0, 1'b1, ex_fetch(1'b1, 2'b00));
    cyc("i_add_decode", OP_I, 3'b000, 1'b1, 1'b0, 1'b1, ex_decode());
    cyc("i_add_execi",  OP_I, 3'b000, 1'b1, 1'b0, 1'b1,
        mk(4'd7, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 2'b00));
    cyc("i_add_aluwb",  OP_I, 3'b000, 1'b1, 1'b0, 1'b1, ex_aluwb());

    // Load where MemReady stays low for 3 cycles in MEMREAD
    cyc("ld_fetch",  OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b1, ex_fetch(1'b1, 2'b00));
    cyc("ld_decode", OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b1, ex_decode());
    cyc("ld_memadr", OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b1,
        mk(4'd2, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 2'b00));
    for (int i = 0; i < 4; i++)
      cyc("ld_memread", OP_LOAD, 3'b010, 1'b0, 1'b0, (i == 3),
          mk(4'd3, 6'b110000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00));
    cyc("ld_memwb", OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b1,
        mk(4'd4, 6'b000001, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00));

    // Store with one wait cycle
    cyc("st_fetch",  OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1, ex_fetch(1'b1, 2'b00));
    cyc("st_decode", OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1, ex_decode());
    cyc("st_memadr", OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1,
        mk(4'd2, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 2'b00));
    for (int i = 0; i < 2; i++)
      cyc("st_memwrite", OP_STORE, 3'b010, 1'b0, 1'b0, (i == 1),
          mk(4'd5, 6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00));

    // BEQ taken (Zero=1), BEQ not taken (Zero=0), BNE taken (Zero=0)
    for (int k = 0; k < 3; k++) begin
      logic [2:0] f3;
      logic       z, taken;
      f3    = (k == 2) ? 3'b001 : 3'b000;
      z     = (k == 0);
      taken = (k != 1);
      cyc("br_fetch",  OP_BR, f3, 1'b0, z, 1'b1, ex_fetch(1'b1, 2'b00));
      cyc("br_decode", OP_BR, f3, 1'b0, z, 1'b1, ex_decode());
      cyc("br_branch", OP_BR, f3, 1'b0, z, 1'b1,
          mk(4'd9, {4'b0000, taken, 1'b0}, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 2'b00));
    end

    // JAL then LUI
    cyc("jal_fetch",  OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, ex_fetch(1'b1, 2'b00));
    cyc("jal_decode", OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, ex_decode());
    cyc("jal_jal",    OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1,
        mk(4'd10, 6'b000010, 2'b00, 2'b01, 2'b10, 3'b000, 3'b100, 2'b00));
    cyc("jal_aluwb",  OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, ex_aluwb());
    cyc("lui_fetch",  OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1, ex_fetch(1'b1, 2'b00));
    cyc("lui_decode", OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1, ex_decode());
    cyc("lui_lui",    OP_LUI, 3'b000, 1'b0, 1'b0, 1'b1,
        mk(4'd11, 6'b000001, 2'b10, 2'b00, 2'b01, 3'b000, 3'b011, 2'b00));

    // MemReady arriving on the 15th FETCH cycle completes without a timeout.
    // The fetched opcode is illegal, which leads to TRAP with Illegal set.
    for (int i = 0; i < 14; i++)
      cyc("wait_edge_fetch", OP_BAD, 3'b000, 1'b0, 1'b0, 1'b0, ex_fetch(1'b0, 2'b00));
    cyc("wait_edge_done", OP_BAD, 3'b000, 1'b0, 1'b0, 1'b1, ex_fetch(1'b1, 2'b00));
    cyc("bad_decode", OP_BAD, 3'b000, 1'b0, 1'b0, 1'b1, ex_decode());
    for (int i = 0; i < 10; i++)
      cyc("bad_trap_hold", OP_BAD, 3'b000, 1'b0, 1'b0, (i % 2 == 0), ex_trap(2'b10));

    // A reset pulse clears TRAP. An R-type with illegal funct3 then traps.
    do_reset("trap_reset");
    cyc("r_bad_fetch",  OP_R, 3'b001, 1'b0, 1'b0, 1'b1, ex_fetch(1'b1, 2'b00));
    cyc("r_bad_decode", OP_R, 3'b001, 1'b0, 1'b0, 1'b1, ex_decode());
    cyc("r_bad_execr",  OP_R, 3'b001, 1'b0, 1'b0, 1'b1,
        mk(4'd6, 6'b000000, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 2'b00));
    for (int i = 0; i < 2; i++)
      cyc("r_bad_trap", OP_R, 3'b001, 1'b0, 1'b0, 1'b1, ex_trap(2'b10));

    // FETCH timeout: 15 cycles without MemReady, then TRAP with MemTimeout
    do_reset("timeout_reset");
    for (int i = 0; i < 15; i++)
      cyc("to_fetch", OP_R, 3'b000, 1'b0, 1'b0, 1'b0, ex_fetch(1'b0, 2'b00));
    for (int i = 0; i < 3; i++)
      cyc("to_trap", OP_R, 3'b000, 1'b0, 1'b0, 1'b1, ex_trap(2'b01));

    // Asynchronous reset in the middle of MEMWRITE
    do_reset("async_pre_reset");
    cyc("ar_fetch",  OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1, ex_fetch(1'b1, 2'b00));
    cyc("ar_decode", OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1, ex_decode());
    cyc("ar_memadr", OP_STORE, 3'b010, 1'b0, 1'b0, 1'b1,
        mk(4'd2, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 2'b00));
    cyc("ar_memwrite", OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0,
        mk(4'd5, 6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00));
    @(posedge clk);
    #1;
    push("ar_still_writing",
         mk(4'd5, 6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00));
    -> chk_now;
    #1;
    rst_n = 1'b0;
    #1;
    push("ar_async_drop", ex_fetch(1'b0, 2'b00));
    -> chk_now;
    cyc("ar_after_release", OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, ex_fetch(1'b0, 2'b00));

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net in case the run ever stalls
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
